multi_tick_gen: RTL and testbench
=================================

// Module: multi_tick_gen
// PURPOSE
//   Parametrised N-channel clock-enable generator for the traffic-light timing path.
//   Each channel divides clk by a runtime-loadable value and produces two outputs:
//   a one-cycle tick strobe and a 50%-style square wave that toggles on every tick.
//   It feeds the phase-timer FSM (tick) and the lamp blink/flash logic (square).
//   Everything stays on the single clk domain; no derived clocks are generated.
// PARAMETERS
//   N_CH         4        number of independent channels
//   W            27       divide-counter width; max period is 2^W-1 cycles
//   DIV_DEFAULT  125000   divide value loaded into every channel at reset
//   LW           $clog2(N_CH) (min 1)   width of load_ch; localparam, not overridable
// PORTS
//   clk        in   1         system clock; all logic on rising edge
//   resetSW_n  in   1         asynchronous, active-low reset
//   en         in   N_CH      per-channel count enable; low = hold counter, tick=0
//   oneshot    in   N_CH      per-channel mode: 0 = free-running, 1 = one-shot
//   restart    in   1         synchronous restart of all channels (phase align)
//   load       in   1         write strobe for the divide register
//   load_ch    in   LW        channel addressed by load
//   load_div   in   W         new divide value
//   tick       out  N_CH      one-cycle strobe, once per period (registered)
//   square     out  N_CH      toggles on each tick (registered)
//   done       out  N_CH      one-shot channel has fired and is halted
// BEHAVIOUR
//   Reset (resetSW_n=0, async): div[i]=DIV_DEFAULT, cnt[i]=0, tick=0, square=0, done=0.
//   Per channel i, each edge, in priority order:
//   - restart=1: cnt=0, tick=0, square=0, done=0.
//   - load=1 and load_ch==i: div=load_div, cnt=0, tick=0, square=0, done=0.
//     Same-edge restart+load: both apply, and div takes load_div.
//     load_ch>=N_CH: the write is ignored.
//   - div==0: channel is halted; cnt=0, tick=0, square holds.
//   - en=0 or done=1: cnt holds, tick=0, square holds.
//   - else if cnt==div-1: cnt=0, tick=1, square=~square, done=oneshot[i].
//   - else: cnt=cnt+1, tick=0.
//   Timing:
//   - Edge E0 = load/restart/reset release. With en held high, tick first rises
//     after edge E_div and repeats every div cycles.
//   - tick high exactly 1 cycle per period.
//   - div=1: tick stays high continuously and square toggles every cycle.
//   Counter rules:
//   - cnt compares against div-1 using W-bit unsigned arithmetic; there is no wrap
//     beyond div-1.
//   - Lowering div below the current cnt via load cannot strand the counter,
//     because a load always zeroes cnt.
//   Other rules:
//   - Period with square wave: 2*div cycles.
//   - oneshot changed mid-count takes effect at the next terminal count.
//   - en low mid-period stretches the period by the number of disabled cycles;
//     the phase is preserved.
//   - Reset mid-operation returns every channel to its DIV_DEFAULT state
//     immediately, without waiting for a clock edge.
// STRUCTURE
//   Package traffic_timing_pkg:
//   - CLK_HZ and the standard divide constants (DIV_1HZ, DIV_2HZ_BLINK, DIV_FAST).
//   - N_CH default.
//   Sub-module tick_channel (one div register, counter, tick/square/done flops),
//   instantiated N_CH times in a generate loop. The top level only decodes load_ch
//   and fans out restart and en.
// TESTING   (bench uses W=8, N_CH=4, DIV_DEFAULT=5)
//   1. Release reset with en=4'b0001 -> ch0 tick at edges 5,10,15; square toggles
//      at the same edges; ch1..3 tick stay 0.
//   2. Load ch2 div=3 while en[2]=1 -> ch2 tick 3 edges after the load and every
//      3 edges after that; ch0 phase is undisturbed.
//   3. Set oneshot[1]=1 with div=4 -> a single tick 4 edges after the load;
//      done[1]=1 and no further ticks; restart clears done and re-arms the channel.
//   4. Load div=1 and div=0 -> div=1 gives a continuous tick with square toggling
//      every cycle; div=0 gives tick=0 and square frozen.
//   5. Drop en mid-period for 3 cycles with div=5 -> that period lasts 8 cycles;
//      the next period is 5 cycles.
//   6. Assert resetSW_n low between edges mid-count -> all outputs go to 0
//      immediately (async); assert restart on the same edge as load on ch0 ->
//      div updated and cnt=0.

Source files
------------

// File: rtl/multi_tick_gen_pkg.sv
// Shared timing constants for the traffic-light clock-enable path.
// Divide values assume a 125 MHz system clock.
package traffic_timing_pkg;

   localparam int CLK_HZ        = 125_000_000;
   localparam int N_CH_DEFAULT  = 4;
   localparam int DIV_1HZ       = CLK_HZ;
   // Square output toggles per tick, so a 2 Hz blink needs a 4 Hz tick.
   localparam int DIV_2HZ_BLINK = CLK_HZ / 4;
   localparam int DIV_FAST      = CLK_HZ / 1000;

endpackage

// File: rtl/multi_tick_gen_tick_channel.sv
// One divide channel: runtime divide register, enable-gated counter, and
// registered tick / square / one-shot done flags.
module tick_channel #(
   parameter int W           = 27,
   parameter int DIV_DEFAULT = 125000
) (
   input  logic         clk,
   input  logic         resetSW_n,
   input  logic         en,
   input  logic         oneshot,
   input  logic         restart,
   input  logic         load_hit,
   input  logic [W-1:0] load_div,
   output logic         tick,
   output logic         square,
   output logic         done
);

   logic [W-1:0] r_div;
   logic [W-1:0] r_cnt;
   logic         r_tick;
   logic         r_square;
   logic         r_done;

   always_ff @(posedge clk or negedge resetSW_n) begin
      if (!resetSW_n) begin
         r_div    <= W'(DIV_DEFAULT);
         r_cnt    <= '0;
         r_tick   <= 1'b0;
         r_square <= 1'b0;
         r_done   <= 1'b0;
      end else if (restart || load_hit) begin
         // Restart and load may land on the same edge; the load still wins for div.
         if (load_hit) r_div <= load_div;
         r_cnt    <= '0;
         r_tick   <= 1'b0;
         r_square <= 1'b0;
         r_done   <= 1'b0;
      end else if (r_div == '0) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (!en || r_done) begin
         r_tick <= 1'b0;
      end else if (r_cnt == r_div - W'(1)) begin
         r_cnt    <= '0;
         r_tick   <= 1'b1;
         r_square <= ~r_square;
         r_done   <= oneshot;
      end else begin
         r_cnt  <= r_cnt + W'(1);
         r_tick <= 1'b0;
      end
   end

   assign tick   = r_tick;
   assign square = r_square;
   assign done   = r_done;

endmodule

// File: rtl/multi_tick_gen.sv
// N-channel clock-enable generator: decodes divide-register writes and fans
// restart / enable out to one tick_channel per output bit.
module multi_tick_gen
   import traffic_timing_pkg::*;
#(
   parameter  int N_CH        = N_CH_DEFAULT,
   parameter  int W           = 27,
   parameter  int DIV_DEFAULT = DIV_FAST,
   localparam int LW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            resetSW_n,
   input  logic [N_CH-1:0] en,
   input  logic [N_CH-1:0] oneshot,
   input  logic            restart,
   input  logic            load,
   input  logic [LW-1:0]   load_ch,
   input  logic [W-1:0]    load_div,
   output logic [N_CH-1:0] tick,
   output logic [N_CH-1:0] square,
   output logic [N_CH-1:0] done
);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic w_load_hit;

      // Addresses at or beyond N_CH match no channel, so such writes vanish.
      assign w_load_hit = load && (int'(load_ch) == g);

      tick_channel #(
         .W           (W),
         .DIV_DEFAULT (DIV_DEFAULT)
      ) u_ch (
         .clk       (clk),
         .resetSW_n (resetSW_n),
         .en        (en[g]),
         .oneshot   (oneshot[g]),
         .restart   (restart),
         .load_hit  (w_load_hit),
         .load_div  (load_div),
         .tick      (tick[g]),
         .square    (square[g]),
         .done      (done[g])
      );
   end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Bench for multi_tick_gen: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_multi_tick_gen;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int DD = 5;

   logic         clk = 1'b0;
   logic         resetSW_n;
   logic [N-1:0] en, oneshot;
   logic         restart, load;
   logic [1:0]   load_ch;
   logic [W-1:0] load_div;
   logic [N-1:0] tick, square, done;

   int n_cmp = 0;
   int n_bad = 0;

   int         m_div [N];
   int         m_el  [N];
   logic [N-1:0] m_tick, m_sq, m_done;

   always #5 clk = ~clk;

   multi_tick_gen #(.N_CH(N), .W(W), .DIV_DEFAULT(DD)) dut (
      .clk       (clk),
      .resetSW_n (resetSW_n),
      .en        (en),
      .oneshot   (oneshot),
      .restart   (restart),
      .load      (load),
      .load_ch   (load_ch),
      .load_div  (load_div),
      .tick      (tick),
      .square    (square),
      .done      (done)
   );

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_div[i] = DD;
         m_el[i]  = 0;
      end
      m_tick = '0; m_sq = '0; m_done = '0;
   endtask

   // Each channel counts enabled cycles since its last tick/clear; a tick
   // happens when that count reaches the divide value.
   task automatic model_step();
      if (!resetSW_n) begin
         model_reset();
         return;
      end
      for (int i = 0; i < N; i++) begin
         bit hit;
         hit = load && (int'(load_ch) == i);
         if (restart || hit) begin
            if (hit) m_div[i] = int'(load_div);
            m_el[i] = 0; m_tick[i] = 0; m_sq[i] = 0; m_done[i] = 0;
         end else if (m_div[i] == 0) begin
            m_el[i] = 0; m_tick[i] = 0;
         end else if (!en[i] || m_done[i]) begin
            m_tick[i] = 0;
         end else begin
            m_el[i] = m_el[i] + 1;
            if (m_el[i] == m_div[i]) begin
               m_el[i]   = 0;
               m_tick[i] = 1;
               m_sq[i]   = ~m_sq[i];
               m_done[i] = oneshot[i];
            end else begin
               m_tick[i] = 0;
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check("tick",   int'(tick),   int'(m_tick));
      check("square", int'(square), int'(m_sq));
      check("done",   int'(done),   int'(m_done));
   endtask

   initial begin
      resetSW_n = 1'b0; en = '0; oneshot = '0; restart = 1'b0; load = 1'b0;
      load_ch = '0; load_div = '0;
      model_reset();
      repeat (2) cycle();
      check("rst_tick", int'(tick), 0);
      check("rst_square", int'(square), 0);
      check("rst_done", int'(done), 0);

      // 1: default divide on ch0 after reset release
      en = 4'b0001; resetSW_n = 1'b1;
      for (int e = 1; e <= 15; e++) begin
         cycle();
         if (e == 4 || e == 5 || e == 10 || e == 15)
            check("s1_tick0", int'(tick[0]), (e % 5 == 0) ? 1 : 0);
         if (e == 5)  check("s1_sq0_up", int'(square[0]), 1);
         if (e == 10) check("s1_sq0_dn", int'(square[0]), 0);
      end
      check("s1_others", int'(tick[3:1]), 0);

      // 2: load ch2 div=3
      en = 4'b0101; load = 1'b1; load_ch = 2'd2; load_div = 8'd3;
      cycle();
      load = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         cycle();
         if (e == 2) check("s2_tick2_early", int'(tick[2]), 0);
         if (e == 3 || e == 6) check("s2_tick2", int'(tick[2]), 1);
      end

      // 3: one-shot on ch1 div=4, then restart re-arms
      en = 4'b0111; oneshot = 4'b0010; load = 1'b1; load_ch = 2'd1; load_div = 8'd4;
      cycle();
      load = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         cycle();
         if (e == 4) begin
            check("s3_tick1", int'(tick[1]), 1);
            check("s3_done1", int'(done[1]), 1);
         end
         if (e == 10) begin
            check("s3_halted_tick1", int'(tick[1]), 0);
            check("s3_halted_done1", int'(done[1]), 1);
         end
      end
      restart = 1'b1;
      cycle();
      restart = 1'b0;
      check("s3_done1_clr", int'(done[1]), 0);
      for (int e = 1; e <= 4; e++) begin
         cycle();
         if (e == 3) check("s3_rearm_early", int'(tick[1]), 0);
         if (e == 4) check("s3_rearm_tick1", int'(tick[1]), 1);
      end
      oneshot = '0;

      // 4: div=1 continuous, div=0 halted
      en = 4'b1001; load = 1'b1; load_ch = 2'd3; load_div = 8'd1;
      cycle();
      load = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         cycle();
         check("s4_div1_tick3", int'(tick[3]), 1);
         check("s4_div1_sq3", int'(square[3]), e % 2);
      end
      load = 1'b1; load_ch = 2'd3; load_div = 8'd0;
      cycle();
      load = 1'b0;
      for (int e = 1; e <= 3; e++) cycle();
      check("s4_div0_tick3", int'(tick[3]), 0);
      check("s4_div0_sq3", int'(square[3]), 0);

      // 5: en dropped 3 cycles mid-period on ch0 (div=5)
      en = 4'b0001; restart = 1'b1;
      cycle();
      restart = 1'b0;
      for (int e = 1; e <= 13; e++) begin
         en[0] = !(e >= 3 && e <= 5);
         cycle();
         if (e == 7)  check("s5_no_tick7", int'(tick[0]), 0);
         if (e == 8)  check("s5_tick8", int'(tick[0]), 1);
         if (e == 12) check("s5_no_tick12", int'(tick[0]), 0);
         if (e == 13) check("s5_tick13", int'(tick[0]), 1);
      end

      // 6: async reset between edges, then restart+load on the same edge
      en = 4'b0001;
      repeat (5) cycle();
      check("s6_sq0_pre", int'(square[0]), 1);
      #3 resetSW_n = 1'b0;
      #1;
      check("s6_async_tick", int'(tick), 0);
      check("s6_async_sq", int'(square), 0);
      check("s6_async_done", int'(done), 0);
      model_reset();
      cycle();
      resetSW_n = 1'b1;
      restart = 1'b1; load = 1'b1; load_ch = 2'd0; load_div = 8'd7;
      cycle();
      restart = 1'b0; load = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         cycle();
         if (e == 6) check("s6_no_tick6", int'(tick[0]), 0);
         if (e == 7) check("s6_tick7", int'(tick[0]), 1);
      end

      // Randomized phase
      repeat (400) begin
         en       = N'($urandom);
         oneshot  = N'($urandom & $urandom & $urandom);
         restart  = ($urandom_range(0, 39) == 0);
         load     = ($urandom_range(0, 5) == 0);
         load_ch  = 2'($urandom_range(0, 3));
         load_div = W'($urandom_range(0, 9));
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
